// File: rtl/data_memory_responder_if.sv
// Load/store request and response channels between a CPU data port and its memory.
// Both channels use valid/ready handshakes; the master drives requests, the slave responds.
interface data_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_we, req_be, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_be, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder: one outstanding word access, fixed LATENCY, image loaded in reset.
// Optional macro MISALIGN_ERR_EN: misaligned addresses return resp_err=1 and never write.
module data_memory_responder #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  data_memory_responder_if.slave bus,
  input  logic [DEPTH-1:0][31:0] initial_values,
  output logic [DEPTH-1:0][31:0] memory_check
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   idx_q;
  logic            we_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem [DEPTH];
  logic [31:0]     cur_word, merged_word;
  logic            accept, access, resp_done, acc_err;
  logic            unused_addr;

  assign bus.req_ready = (state == IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign access        = (state == WAIT) && (cnt == '0);
  assign resp_done     = (state == RESP) && bus.resp_valid && bus.resp_ready;

`ifdef MISALIGN_ERR_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (reset)       misalign_q <= 1'b0;
    else if (accept) misalign_q <= |bus.req_addr[1:0];
  end

  assign acc_err     = misalign_q;
  assign unused_addr = ^bus.req_addr[31:AW+2];
`else
  assign acc_err     = 1'b0;
  assign unused_addr = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};
`endif

  // NOTE: state-holding processes use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: each always_comb output gets a default first, so no path can leave it unassigned (latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)    state_next = WAIT;
      WAIT:    if (access)    state_next = RESP;
      RESP:    if (resp_done) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Byte-lane merge of the latched store data over the currently addressed word.
  always_comb begin
    cur_word    = mem[idx_q];
    merged_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merged_word[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // NOTE: the array is reloaded from a port in reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= initial_values[i];
    end else if (access && we_q && !acc_err) begin
      mem[idx_q] <= merged_word;
    end
  end

  always_comb begin
    memory_check = '0;
    for (int i = 0; i < DEPTH; i++) memory_check[i] = mem[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      idx_q          <= '0;
      we_q           <= 1'b0;
      be_q           <= '0;
      wdata_q        <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        idx_q   <= bus.req_addr[AW+1:2];
        we_q    <= bus.req_we;
        be_q    <= bus.req_be;
        wdata_q <= bus.req_wdata;
        cnt     <= CW'(LATENCY - 1);
      end
      if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;

      if (access) begin
        bus.resp_valid <= 1'b1;
        bus.resp_err   <= acc_err;
        bus.resp_rdata <= acc_err ? 32'h0 : (we_q ? merged_word : cur_word);
      end else if (resp_done) begin
        bus.resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed plus random bench for data_memory_responder against an array-based memory model.
// Honors MISALIGN_ERR_EN the same way the design does.
module tb_data_memory_responder;
  localparam int DEPTH   = 32;
  localparam int LATENCY = 2;

`ifdef MISALIGN_ERR_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [DEPTH-1:0][31:0] initial_values;
  logic [DEPTH-1:0][31:0] memory_check;

  data_memory_responder_if bus ();

  data_memory_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .initial_values (initial_values),
    .memory_check   (memory_check)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] ref_mem [DEPTH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = -1;
    for (int i = 0; i < DEPTH; i++)
      if (bad < 0 && memory_check[i] !== ref_mem[i]) bad = i;
    checks++;
    assert (bad < 0) else begin
      errors++;
      $error("FAIL %s: word %0d observed=%h expected=%h", tag, bad, memory_check[bad], ref_mem[bad]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = initial_values[i];
  endtask

  // Reference behaviour: word index wraps modulo DEPTH, enabled bytes replace old bytes.
  task automatic model_access(input logic [31:0] addr, input logic we, input logic [3:0] be,
                              input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int unsigned idx;
    logic [31:0] mask;
    idx = (addr / 4) % DEPTH;
    if (MISALIGN_EN && (addr % 4) != 0) begin
      err   = 1'b1;
      rdata = 32'h0;
    end else begin
      err = 1'b0;
      if (we) begin
        mask = 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
        ref_mem[idx] = (ref_mem[idx] & ~mask) | (wdata & mask);
      end
      rdata = ref_mem[idx];
    end
  endtask

  // One complete transaction; hold = cycles resp_ready stays low, spam = offer a rival request meanwhile.
  task automatic do_req(input string tag, input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wdata, input int hold, input bit spam,
                        output logic [31:0] got_rdata, output logic got_err);
    logic [31:0] exp_rdata, held_rdata;
    logic exp_err, held_err;
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin tick(); n++; end
    check({tag, "_ready_idle"}, 32'(bus.req_ready), 32'd1);

    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_we    = we;
    bus.req_be    = be;
    bus.req_wdata = wdata;
    bus.resp_ready = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_we    = 1'($urandom);
    bus.req_be    = 4'($urandom);
    bus.req_wdata = $urandom;
    model_access(addr, we, be, wdata, exp_rdata, exp_err);
    check({tag, "_ready_busy"}, 32'(bus.req_ready), 32'd0);

    n = 0;
    while (!bus.resp_valid && n < LATENCY + 20) begin tick(); n++; end
    check({tag, "_latency"}, 32'(n), 32'(LATENCY));
    check({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
    check_mem({tag, "_mem_access"});
    got_rdata  = bus.resp_rdata;
    got_err    = bus.resp_err;
    held_rdata = bus.resp_rdata;
    held_err   = bus.resp_err;

    for (int h = 0; h < hold; h++) begin
      if (spam) begin
        bus.req_valid = 1'b1;
        bus.req_addr  = $urandom;
        bus.req_we    = 1'b1;
        bus.req_be    = 4'hF;
        bus.req_wdata = $urandom;
      end
      tick();
      check({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
      check({tag, "_hold_rdata"}, bus.resp_rdata, held_rdata);
      check({tag, "_hold_err"}, 32'(bus.resp_err), 32'(held_err));
      check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;

    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
    check_mem({tag, "_mem_after"});
  endtask

  initial begin
    logic [31:0] r;
    logic e;
    logic [31:0] a;
    logic saw_valid;

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_we     = 1'b0;
    bus.req_be     = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) initial_values[i] = 32'(i * 16);

    do_reset();
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_mem("rst_image");

    do_req("t1_load", 32'h0C, 1'b0, 4'h0, 32'h0, 0, 1'b0, r, e);
    check("t1_rdata_const", r, 32'h30);

    do_req("t2_fill", 32'h08, 1'b1, 4'hF, 32'h11223344, 0, 1'b0, r, e);
    do_req("t2_merge", 32'h08, 1'b1, 4'b0101, 32'hDEADBEEF, 0, 1'b0, r, e);
    check("t2_merge_const", r, 32'h11AD33EF);
    check("t2_memchk_const", memory_check[2], 32'h11AD33EF);
    do_req("t2_reload", 32'h08, 1'b0, 4'h0, 32'h0, 1, 1'b0, r, e);
    check("t2_reload_const", r, 32'h11AD33EF);

    do_req("t3_stall", 32'h10, 1'b0, 4'h0, 32'h0, 5, 1'b1, r, e);

    do_req("t4_wrap", 32'h80, 1'b1, 4'hF, 32'h55, 0, 1'b0, r, e);
    check("t4_memchk0", memory_check[0], 32'h55);

    // Abort a store mid-latency with reset.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h04;
    bus.req_we    = 1'b1;
    bus.req_be    = 4'hF;
    bus.req_wdata = 32'hCAFEF00D;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < LATENCY - 1; i++) tick();
    do_reset();
    saw_valid = bus.resp_valid;
    for (int i = 0; i < 4; i++) begin
      tick();
      saw_valid = saw_valid | bus.resp_valid;
    end
    check("t5_no_resp", 32'(saw_valid), 32'd0);
    check("t5_memchk1", memory_check[1], 32'h10);
    check_mem("t5_image");

    do_req("t6_misalign", 32'h06, 1'b0, 4'h0, 32'h0, 0, 1'b0, r, e);
    check("t6_rdata_const", r, MISALIGN_EN ? 32'h0 : 32'h10);
    check("t6_err_const", 32'(e), MISALIGN_EN ? 32'd1 : 32'd0);

    do_req("be0_noop", 32'h14, 1'b1, 4'h0, 32'hFFFFFFFF, 0, 1'b0, r, e);
    check("be0_rdata_const", r, 32'h50);

    for (int k = 0; k < 60; k++) begin
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      do_req($sformatf("rnd%0d", k), a, 1'($urandom_range(1)), 4'($urandom), $urandom,
             int'($urandom_range(2)), 1'($urandom_range(1)), r, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
